// File: rtl/bist_scan_ctrl_if.sv
// rtl/bist_scan_ctrl_if.sv - BIST scan controller handshake and scan-chain signal bundle (misr_sig present with BIST_SIG_OUT_EN)
interface bist_scan_ctrl_if;
   logic        bist_start;
   logic        scan_out;
   logic        scan_en;
   logic        scan_in;
   logic        cut_capture;
   logic        busy;
   logic        bist_end;
   logic        pass_nfail;
`ifdef BIST_SIG_OUT_EN
   logic [15:0] misr_sig;
`endif

   modport slave (
      input  bist_start,
      input  scan_out,
      output scan_en,
      output scan_in,
      output cut_capture,
      output busy,
      output bist_end,
      output pass_nfail
`ifdef BIST_SIG_OUT_EN
      ,
      output misr_sig
`endif
   );

   modport master (
      output bist_start,
      output scan_out,
      input  scan_en,
      input  scan_in,
      input  cut_capture,
      input  busy,
      input  bist_end,
      input  pass_nfail
`ifdef BIST_SIG_OUT_EN
      ,
      input  misr_sig
`endif
   );
endinterface

// File: rtl/bist_scan_ctrl.sv
// rtl/bist_scan_ctrl.sv - logic BIST controller: LFSR scan stimulus, capture, MISR compaction (BIST_SIG_OUT_EN exports misr_sig)
module bist_scan_ctrl #(
   parameter int          CHAIN_LEN    = 8,
   parameter int          NUM_PATTERNS = 16,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
   input logic               clock,
   input logic               reset,
   bist_scan_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CAPTURE,
      UNLOAD,
      COMPARE,
      DONE
   } state_t;

   localparam logic [7:0] SHIFT_LAST = 8'(CHAIN_LEN - 1);
   localparam logic [7:0] PAT_LAST   = 8'(NUM_PATTERNS - 1);

   state_t      state;
   logic [15:0] lfsr;
   logic [15:0] misr;
   logic [7:0]  shift_cnt;
   logic [7:0]  pat_cnt;
   logic [15:0] lfsr_nxt;
   logic [15:0] misr_nxt;

   // Next LFSR/MISR values for x^16+x^14+x^13+x^11+1, shifting toward bit 0
   always_comb begin
      lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      misr_nxt = {misr[0] ^ misr[2] ^ misr[3] ^ misr[5] ^ bus.scan_out, misr[15:1]};
   end

   // Run sequencer; every output is registered alongside the state it belongs to
   always_ff @(posedge clock) begin
      if (!reset) begin
         state           <= IDLE;
         lfsr            <= LFSR_SEED;
         misr            <= 16'h0000;
         shift_cnt       <= 8'd0;
         pat_cnt         <= 8'd0;
         bus.scan_en     <= 1'b0;
         bus.scan_in     <= 1'b0;
         bus.cut_capture <= 1'b0;
         bus.busy        <= 1'b0;
         bus.bist_end    <= 1'b0;
         bus.pass_nfail  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.bist_start) begin
                  state          <= SHIFT;
                  lfsr           <= LFSR_SEED;
                  misr           <= 16'h0000;
                  shift_cnt      <= 8'd0;
                  pat_cnt        <= 8'd0;
                  bus.scan_en    <= 1'b1;
                  bus.scan_in    <= LFSR_SEED[0];
                  bus.busy       <= 1'b1;
                  bus.pass_nfail <= 1'b0;
               end
            end
            SHIFT: begin
               lfsr <= lfsr_nxt;
               // The first pattern unloads an uninitialised chain, so it is not compacted
               if (pat_cnt != 8'd0) begin
                  misr <= misr_nxt;
               end
               if (shift_cnt == SHIFT_LAST) begin
                  shift_cnt       <= 8'd0;
                  state           <= CAPTURE;
                  bus.scan_en     <= 1'b0;
                  bus.scan_in     <= 1'b0;
                  bus.cut_capture <= 1'b1;
               end else begin
                  shift_cnt   <= shift_cnt + 8'd1;
                  bus.scan_in <= lfsr_nxt[0];
               end
            end
            CAPTURE: begin
               bus.cut_capture <= 1'b0;
               bus.scan_en     <= 1'b1;
               pat_cnt         <= pat_cnt + 8'd1;
               if (pat_cnt == PAT_LAST) begin
                  state       <= UNLOAD;
                  bus.scan_in <= 1'b0;
               end else begin
                  state       <= SHIFT;
                  bus.scan_in <= lfsr[0];
               end
            end
            UNLOAD: begin
               misr <= misr_nxt;
               if (shift_cnt == SHIFT_LAST) begin
                  shift_cnt   <= 8'd0;
                  state       <= COMPARE;
                  bus.scan_en <= 1'b0;
               end else begin
                  shift_cnt <= shift_cnt + 8'd1;
               end
            end
            COMPARE: begin
               state          <= DONE;
               bus.pass_nfail <= (misr == GOLDEN_SIG);
               bus.busy       <= 1'b0;
               bus.bist_end   <= 1'b1;
            end
            DONE: begin
               // A held start does not retrigger; the requester must drop it first
               if (!bus.bist_start) begin
                  state        <= IDLE;
                  bus.bist_end <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef BIST_SIG_OUT_EN
   assign bus.misr_sig = misr;
`endif

endmodule

// File: tb/tb_bist_scan_ctrl.sv
// tb/tb_bist_scan_ctrl.sv - directed self-checking bench for bist_scan_ctrl
module tb_bist_scan_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   tests  = 0;
   int   failed = 0;

   bist_scan_ctrl_if bus ();

   bist_scan_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] misr_ref(input logic [15:0] m, input logic d);
      return {m[0] ^ m[2] ^ m[3] ^ m[5] ^ d, m[15:1]};
   endfunction

   function automatic logic [5:0] outs();
      return {bus.scan_en, bus.scan_in, bus.cut_capture, bus.busy, bus.bist_end, bus.pass_nfail};
   endfunction

   // mode 0: scan_out 0; 1: single 1 on 4th unload cycle; 2: toggled pattern
   task automatic do_run(input int mode, input bit drop_start, output int lat, output int caps,
                         output int bad_caps, output logic [15:0] sin_word, output logic [15:0] model);
      int sen_idx;
      int run_len;
      int nbits;
      lat = 0; caps = 0; bad_caps = 0; sin_word = 16'h0; model = 16'h0;
      sen_idx = 0; run_len = 0; nbits = 0;
      bus.bist_start = 1'b1;
      bus.scan_out   = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clock);
         if (drop_start && k == 20) bus.bist_start = 1'b0;
         if (bus.bist_end) begin
            lat = k;
            bus.scan_out = 1'b0;
            break;
         end
         bus.scan_out = 1'b0;
         if (bus.cut_capture) begin
            caps++;
            if (bus.scan_en || run_len != 8) bad_caps++;
         end
         if (bus.scan_en) begin
            sen_idx++;
            run_len++;
            if (nbits < 16) begin
               sin_word[nbits] = bus.scan_in;
               nbits++;
            end
            if (mode == 1 && sen_idx == 132) bus.scan_out = 1'b1;
            if (mode == 2) bus.scan_out = (sen_idx % 3 == 0) || (sen_idx % 7 == 1);
            if (sen_idx > 8) model = misr_ref(model, bus.scan_out);
         end else begin
            run_len = 0;
         end
      end
   endtask

   int          lat, caps, bad_caps, ones;
   logic [15:0] sin_word, model;

   initial begin
      bus.bist_start = 1'b0;
      bus.scan_out   = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_outputs", 32'(outs()), 32'h0);
      reset = 1'b1;
      @(negedge clock);

      // Run A: clean chain, start held through DONE
      do_run(0, 1'b0, lat, caps, bad_caps, sin_word, model);
      check("a_latency", lat, 154);
      check("a_pass", 32'(bus.pass_nfail), 32'h1);
      check("a_captures", caps, 16);
      check("a_capture_shape", bad_caps, 0);
      check("a_scan_in_bits", 32'(sin_word), 32'hACE1);
      check("a_busy_done", 32'(bus.busy), 32'h0);
      ones = 0;
      repeat (20) begin
         @(negedge clock);
         if (bus.bist_end) ones++;
      end
      check("a_done_hold", ones, 20);
      bus.bist_start = 1'b0;
      @(negedge clock);
      check("a_end_after_drop", 32'({bus.bist_end, bus.busy}), 32'h0);

      // Run B: one faulty unload bit, start dropped mid-run
      do_run(1, 1'b1, lat, caps, bad_caps, sin_word, model);
      check("b_latency", lat, 154);
      check("b_fail", 32'(bus.pass_nfail), 32'h0);
      @(negedge clock);
      check("b_idle", 32'({bus.bist_end, bus.busy}), 32'h0);

      // Run C: reset mid-run, then a fresh full run
      bus.bist_start = 1'b1;
      repeat (40) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("c_reset_abort", 32'(outs()), 32'h0);
      reset = 1'b1;
      do_run(0, 1'b0, lat, caps, bad_caps, sin_word, model);
      check("c_latency", lat, 154);
      check("c_pass", 32'(bus.pass_nfail), 32'h1);
      bus.bist_start = 1'b0;
      @(negedge clock);

`ifdef BIST_SIG_OUT_EN
      check("d_sig_zero", 32'(bus.misr_sig), 32'h0);
      do_run(2, 1'b0, lat, caps, bad_caps, sin_word, model);
      check("d_latency", lat, 154);
      check("d_sig_model", 32'(bus.misr_sig), 32'(model));
      check("d_pass_model", 32'(bus.pass_nfail), 32'(model == 16'h0));
      bus.bist_start = 1'b0;
      @(negedge clock);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
